// File: rtl/scope_pkg.sv
// Shared types and helpers for the XY scope pattern generator.
package scope_pkg;

    localparam int unsigned CoordW = 8;

    // One table entry as seen on the config write port: {blank, x, y}
    typedef struct packed {
        logic              blank;
        logic [CoordW-1:0] x;
        logic [CoordW-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SHOW = 2'd2
    } state_e;

    // Add or subtract an unsigned offset and clamp to [0, maxv]; one spare
    // bit above the coordinate width catches the overflow before clamping.
    function automatic logic [15:0] sat_add(input logic [15:0] base,
                                            input logic [15:0] off,
                                            input logic        add,
                                            input logic [15:0] maxv);
        logic [16:0] sum;
        sum = '0;
        if (add) begin
            sum = {1'b0, base} + {1'b0, off};
            return (sum > {1'b0, maxv}) ? maxv : sum[15:0];
        end
        return (off > base) ? 16'd0 : (base - off);
    endfunction

endpackage

// File: rtl/scope_pattern_gen_lfsr.sv
// 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1), steps only when enabled.
module scope_pattern_gen_lfsr #(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        preset_i,
    input  logic [15:0] preset_val_i,
    output logic [15:0] state_o,
    output logic        bits_o
);

    logic fb;

    assign fb     = state_o[15] ^ state_o[13] ^ state_o[12] ^ state_o[10];
    assign bits_o = state_o[15];

    // State register; an all-zero preset would lock up, so it falls back to the seed
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_o <= Seed;
        end else if (preset_i) begin
            state_o <= (preset_val_i == '0) ? Seed : preset_val_i;
        end else if (enable_i) begin
            state_o <= {state_o[14:0], fb};
        end
    end

endmodule

// File: rtl/scope_pattern_gen.sv
// XY vector-pattern generator: replays a writable point table as a frame loop
// with per-point dwell and optional saturating jitter, over a valid/ready stream.
module scope_pattern_gen
    import scope_pkg::*;
#(
    parameter  int unsigned CoordWidth  = 8,
    parameter  int unsigned Depth       = 64,
    parameter  int unsigned DwellWidth  = 8,
    parameter  int unsigned JitterWidth = 1,
    localparam int unsigned AddrW       = $clog2(Depth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_wr_en_i,
    input  logic [AddrW-1:0]        cfg_wr_addr_i,
    input  logic [2*CoordWidth:0]   cfg_wr_data_i,
    input  logic [AddrW:0]          cfg_len_i,
    input  logic [DwellWidth-1:0]   cfg_dwell_i,
    input  logic                    cfg_jitter_en_i,
    input  logic                    run_i,
    output logic [CoordWidth-1:0]   o_x,
    output logic [CoordWidth-1:0]   o_y,
    output logic                    o_blank,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_frame_end
);

    typedef struct packed {
        logic                  blank;
        logic [CoordWidth-1:0] x;
        logic [CoordWidth-1:0] y;
    } entry_t;

    localparam logic [15:0] CoordMax = 16'((1 << CoordWidth) - 1);

    entry_t                  mem [Depth];
    entry_t                  rd_q;
    state_e                  state_q;
    logic [AddrW-1:0]        idx_q;
    logic [AddrW:0]          len_q;
    logic [DwellWidth-1:0]   dwell_q;
    logic [DwellWidth-1:0]   dwell_cnt_q;
    logic                    jit_q;
    logic                    beat;
    logic                    last_pt;
    logic [15:0]             lfsr_state;
    logic                    lfsr_bit;
    logic                    unused_lfsr;
    logic [JitterWidth-1:0]  jx;
    logic [JitterWidth-1:0]  jy;
    logic [CoordWidth-1:0]   x_j;
    logic [CoordWidth-1:0]   y_j;

    assign beat    = o_valid && i_ready;
    assign last_pt = ({1'b0, idx_q} + {{AddrW{1'b0}}, 1'b1}) == len_q;

    // Point table: one write port, one registered read port fired in READ.
    // A same-cycle write to the address being read returns the old entry.
    always_ff @(posedge clk_i) begin
        if (cfg_wr_en_i) begin
            mem[cfg_wr_addr_i] <= cfg_wr_data_i;
        end
        if (state_q == READ) begin
            rd_q <= mem[idx_q];
        end
    end

    // Jitter source advances once per accepted beat, so a held sample never changes
    scope_pattern_gen_lfsr u_lfsr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (beat),
        .preset_i     (1'b0),
        .preset_val_i (16'h0000),
        .state_o      (lfsr_state),
        .bits_o       (lfsr_bit)
    );

    assign jx          = lfsr_state[3 -: JitterWidth];
    assign jy          = lfsr_state[9 -: JitterWidth];
    assign unused_lfsr = ^lfsr_state;

    // Jittered coordinates; blanked points pass through untouched
    always_comb begin
        x_j = rd_q.x;
        y_j = rd_q.y;
        if (jit_q && !rd_q.blank) begin
            x_j = CoordWidth'(sat_add(16'(rd_q.x), 16'(jx), lfsr_bit, CoordMax));
            y_j = CoordWidth'(sat_add(16'(rd_q.y), 16'(jy), lfsr_bit, CoordMax));
        end
    end

    // Sample fields are driven only while valid, so reset and bubbles read as zero
    assign o_x     = o_valid ? x_j : '0;
    assign o_y     = o_valid ? y_j : '0;
    assign o_blank = o_valid ? rd_q.blank : 1'b0;

    // Frame sequencer: walks the table, counts dwell beats, owns valid and frame_end.
    // Config is latched only at frame start so mid-frame edits wait for the boundary.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            len_q       <= '0;
            dwell_q     <= '0;
            jit_q       <= 1'b0;
            o_valid     <= 1'b0;
            o_frame_end <= 1'b0;
        end else begin
            o_frame_end <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (run_i && cfg_len_i != '0) begin
                        len_q       <= cfg_len_i;
                        dwell_q     <= cfg_dwell_i;
                        jit_q       <= cfg_jitter_en_i;
                        idx_q       <= '0;
                        dwell_cnt_q <= '0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    state_q <= SHOW;
                    o_valid <= 1'b1;
                end
                SHOW: begin
                    if (beat) begin
                        if (dwell_cnt_q < dwell_q) begin
                            dwell_cnt_q <= dwell_cnt_q + DwellWidth'(1);
                        end else begin
                            dwell_cnt_q <= '0;
                            o_valid     <= 1'b0;
                            if (last_pt) begin
                                idx_q       <= '0;
                                o_frame_end <= 1'b1;
                                len_q       <= cfg_len_i;
                                dwell_q     <= cfg_dwell_i;
                                jit_q       <= cfg_jitter_en_i;
                                state_q     <= (run_i && cfg_len_i != '0) ? READ : IDLE;
                            end else begin
                                idx_q   <= idx_q + AddrW'(1);
                                state_q <= run_i ? READ : IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scope_pattern_gen.sv
// Directed bench for scope_pattern_gen: a cycle table for the basic frame loop,
// plus hand-written sequences for dwell/backpressure, jitter, config, stop and reset.
module tb_scope_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [16:0] wr_data = '0;
    logic [6:0]  len = '0;
    logic [7:0]  dwell = '0;
    logic        jit = 1'b0;
    logic        run = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  o_x, o_y;
    logic        o_blank, o_valid, o_fe;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scope_pattern_gen #(.CoordWidth(8), .Depth(64), .DwellWidth(8), .JitterWidth(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_wr_en_i(wr_en), .cfg_wr_addr_i(wr_addr),
        .cfg_wr_data_i(wr_data), .cfg_len_i(len), .cfg_dwell_i(dwell),
        .cfg_jitter_en_i(jit), .run_i(run), .o_x(o_x), .o_y(o_y), .o_blank(o_blank),
        .o_valid(o_valid), .i_ready(rdy), .o_frame_end(o_fe)
    );

    typedef struct {
        logic       run;
        logic       rdy;
        logic       v;
        logic [7:0] x;
        logic [7:0] y;
        logic       b;
        logic       fe;
    } vec_t;

    vec_t tv [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic b, input logic [7:0] x, input logic [7:0] y);
        wr_en = 1'b1; wr_addr = a; wr_data = {b, x, y};
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_basic();
        wr(6'd0, 1'b0, 8'd10, 8'd20);
        wr(6'd1, 1'b0, 8'd30, 8'd40);
        wr(6'd2, 1'b1, 8'd50, 8'd60);
    endtask

    task automatic do_reset();
        run = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] px_tab [3];
    logic [7:0] py_tab [3];
    logic [7:0] bx [16];
    logic [7:0] by [16];
    logic       pv, pb;
    logic [7:0] px, py;
    logic       seen, found;
    int         nb, pt;
    logic       prev_v;

    initial begin
        px_tab[0] = 8'd10; px_tab[1] = 8'd30; px_tab[2] = 8'd50;
        py_tab[0] = 8'd20; py_tab[1] = 8'd40; py_tab[2] = 8'd60;
        //            run   rdy   v     x      y      b     fe
        tv[0] = '{1'b1, 1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b1, 1'b1, 8'd30, 8'd40, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1'b1, 8'd50, 8'd60, 1'b1, 1'b0};
        tv[6] = '{1'b1, 1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1'b1};
        tv[7] = '{1'b1, 1'b1, 1'b1, 8'd10, 8'd20, 1'b0, 1'b0};
        tv[8] = '{1'b1, 1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
        tv[9] = '{1'b1, 1'b1, 1'b1, 8'd30, 8'd40, 1'b0, 1'b0};

        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_fe",    32'(o_fe), 0);
        chk("rst_x",     32'(o_x), 0);
        chk("rst_y",     32'(o_y), 0);
        chk("rst_blank", 32'(o_blank), 0);
        rst_n = 1'b1;

        // 1: basic frame loop, cycle by cycle
        len = 7'd3; dwell = 8'd0; jit = 1'b0; rdy = 1'b1;
        load_basic();
        for (int i = 0; i < 10; i++) begin
            run = tv[i].run; rdy = tv[i].rdy;
            tick();
            chk($sformatf("t1_valid[%0d]", i), 32'(o_valid), 32'(tv[i].v));
            chk($sformatf("t1_fe[%0d]", i), 32'(o_fe), 32'(tv[i].fe));
            if (tv[i].v) begin
                chk($sformatf("t1_xyb[%0d]", i), 32'({o_x, o_y, o_blank}),
                    32'({tv[i].x, tv[i].y, tv[i].b}));
            end
        end

        // 2: dwell=2 with ready toggling; each point accepted three times, held while stalled
        do_reset();
        len = 7'd3; dwell = 8'd2; run = 1'b1;
        nb = 0;
        for (int c = 0; c < 200 && nb < 12; c++) begin
            rdy = (c % 2 == 0);
            pv = o_valid; px = o_x; py = o_y;
            tick();
            if (pv && rdy) begin
                bx[nb] = px; by[nb] = py; nb++;
            end else if (pv) begin
                chk("t2_hold", 32'({o_valid, o_x, o_y}), 32'({1'b1, px, py}));
            end
        end
        chk("t2_beats", 32'(nb), 12);
        for (int i = 0; i < 12 && i < nb; i++) begin
            chk($sformatf("t2_beat[%0d]", i), 32'({bx[i], by[i]}),
                32'({px_tab[(i / 3) % 3], py_tab[(i / 3) % 3]}));
        end

        // 3: jitter with saturation at both ends, blank point untouched
        wr(6'd0, 1'b0, 8'd0, 8'd0);
        wr(6'd1, 1'b0, 8'd255, 8'd255);
        wr(6'd2, 1'b1, 8'd50, 8'd60);
        do_reset();
        len = 7'd3; dwell = 8'd3; jit = 1'b1; rdy = 1'b1; run = 1'b1;
        pt = 0; prev_v = 1'b0; seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (prev_v && !o_valid) pt = (pt + 1) % 3;
            prev_v = o_valid;
            if (o_valid) begin
                case (pt)
                    0: begin
                        chk("t3_p0_range", 32'(o_x <= 8'd3 && o_y <= 8'd3 && !o_blank), 1);
                        if (o_x != 8'd0 || o_y != 8'd0) seen = 1'b1;
                    end
                    1: chk("t3_p1_range", 32'(o_x >= 8'd252 && o_y >= 8'd252 && !o_blank), 1);
                    default: chk("t3_p2_blank", 32'({o_blank, o_x, o_y}), 32'({1'b1, 8'd50, 8'd60}));
                endcase
            end
        end
        chk("t3_jitter_seen", 32'(seen), 1);
        jit = 1'b0;

        // 4: len 3 -> 1 mid-frame takes effect at the next frame
        load_basic();
        do_reset();
        len = 7'd3; dwell = 8'd0; rdy = 1'b1; run = 1'b1;
        nb = 0;
        for (int c = 0; c < 100 && nb < 6; c++) begin
            pv = o_valid; px = o_x;
            tick();
            if (pv) begin
                bx[nb] = px; nb++;
                len = 7'd1;
            end
        end
        chk("t4_beats", 32'(nb), 6);
        chk("t4_b0", 32'(bx[0]), 10);
        chk("t4_b1", 32'(bx[1]), 30);
        chk("t4_b2", 32'(bx[2]), 50);
        chk("t4_b3", 32'(bx[3]), 10);
        chk("t4_b4", 32'(bx[4]), 10);
        chk("t4_b5", 32'(bx[5]), 10);

        // 5: stop during dwell of point 1, then len=0 keeps output idle
        do_reset();
        len = 7'd3; dwell = 8'd2; rdy = 1'b1; run = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            tick();
            if (o_valid && o_x == 8'd30) found = 1'b1;
        end
        chk("t5_reach_p1", 32'(found), 1);
        run = 1'b0;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            pv = o_valid; px = o_x;
            tick();
            if (pv) begin
                chk("t5_beat_x", 32'(px), 30);
                nb++;
            end
        end
        chk("t5_beats", 32'(nb), 3);
        chk("t5_idle", 32'(o_valid), 0);
        len = 7'd0; run = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t5_len0_valid", 32'(o_valid), 0);
        end

        // 6: reset mid-SHOW, restart latency, table retained, write during READ
        len = 7'd3; dwell = 8'd2; rdy = 1'b0; run = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (o_valid) found = 1'b1;
        end
        chk("t6_show", 32'(found), 1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_outs", 32'({o_valid, o_fe, o_blank, o_x, o_y}), 0);
        rst_n = 1'b1; dwell = 8'd0; rdy = 1'b1;
        tick();
        chk("t6_lat1_valid", 32'(o_valid), 0);
        tick();
        chk("t6_lat2_p0", 32'({o_valid, o_x, o_y}), 32'({1'b1, 8'd10, 8'd20}));
        tick();
        chk("t6_bubble", 32'(o_valid), 0);
        wr(6'd1, 1'b0, 8'd99, 8'd98);
        chk("t6_old_data", 32'({o_valid, o_x, o_y}), 32'({1'b1, 8'd30, 8'd40}));
        tick();
        tick();
        chk("t6_p2", 32'({o_valid, o_blank, o_x, o_y}), 32'({1'b1, 1'b1, 8'd50, 8'd60}));
        tick();
        chk("t6_fe", 32'({o_valid, o_fe}), 32'({1'b0, 1'b1}));
        tick();
        tick();
        tick();
        chk("t6_new_data", 32'({o_valid, o_x, o_y}), 32'({1'b1, 8'd99, 8'd98}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
